timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 135 +++++++++++++
 tb/tb_timer_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: NCH down-counting timers with memory-mapped COUNT/RELOAD/CTRL/STATUS registers.
// Define TIMER_PRESCALER_EN to add the shared tick prescaler (global register 5).
module timer_bank #(
  parameter int WIDTH   = 64,
  parameter int NCH     = 4,
  parameter int SEL_BIT = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [WIDTH-1:0] io_dout,
  output logic [WIDTH-1:0] io_din,
  output logic [NCH-1:0]   irq_vec,
  output logic             interrupt_request
);

  localparam logic [3:0] R_COUNT    = 4'd0;
  localparam logic [3:0] R_RELOAD   = 4'd1;
  localparam logic [3:0] R_CTRL     = 4'd2;
  localparam logic [3:0] R_STATUS   = 4'd3;
  localparam logic [3:0] R_IRQSUM   = 4'd4;
  localparam logic [3:0] R_PRESCALE = 4'd5;

  logic [WIDTH-1:0] count  [NCH];
  logic [WIDTH-1:0] reload [NCH];
  logic [NCH-1:0]   en, periodic, ie, pend;

  logic       sel, wr, tick;
  logic [3:0] reg_idx, ch_idx;

  assign sel     = io_addr[SEL_BIT];
  assign wr      = io_wr & sel;
  assign reg_idx = io_addr[3:0];
  assign ch_idx  = io_addr[7:4];

  // Reads never change state; io_rd exists only for bus symmetry.
  logic unused_bits;
  assign unused_bits = ^{io_rd, io_addr};

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale, presc_cnt;

  assign tick = (presc_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale  <= '0;
      presc_cnt <= '0;
    end else if (wr && reg_idx == R_PRESCALE) begin
      prescale  <= io_dout[15:0];
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    io_din = '0;
    if (sel) begin
      case (reg_idx)
        R_IRQSUM: io_din[NCH-1:0] = pend & ie;
`ifdef TIMER_PRESCALER_EN
        R_PRESCALE: io_din[15:0] = prescale;
`endif
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (ch_idx == 4'(i)) begin
              case (reg_idx)
                R_COUNT:  io_din = count[i];
                R_RELOAD: io_din = reload[i];
                R_CTRL:   io_din[2:0] = {ie[i], periodic[i], en[i]};
                R_STATUS: io_din[0] = pend[i];
                default:  ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Statement order sets priority: W1C, then expiry, then COUNT/CTRL writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
      end
      en       <= '0;
      periodic <= '0;
      ie       <= '0;
      pend     <= '0;
      irq_vec  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr && ch_idx == 4'(i) && reg_idx == R_STATUS && io_dout[0])
          pend[i] <= 1'b0;

        if (tick && en[i]) begin
          if (count[i] != '0) begin
            count[i] <= count[i] - WIDTH'(1);
          end else begin
            pend[i] <= 1'b1;
            if (periodic[i]) count[i] <= reload[i];
            else             en[i]    <= 1'b0;
          end
        end

        if (wr && ch_idx == 4'(i)) begin
          case (reg_idx)
            R_COUNT:  count[i]  <= io_dout;
            R_RELOAD: reload[i] <= io_dout;
            R_CTRL: begin
              en[i]       <= io_dout[0];
              periodic[i] <= io_dout[1];
              ie[i]       <= io_dout[2];
            end
            default: ;
          endcase
        end
      end
      irq_vec <= pend & ie;
    end
  end

  assign interrupt_request = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (default parameters, tick every clock unless prescaled).
module tb_timer_bank;

  localparam int WIDTH   = 64;
  localparam int NCH     = 4;
  localparam int SEL_BIT = 14;

  logic             clk;
  logic             reset;
  logic             io_rd;
  logic             io_wr;
  logic [15:0]      io_addr;
  logic [WIDTH-1:0] io_dout;
  logic [WIDTH-1:0] io_din;
  logic [NCH-1:0]   irq_vec;
  logic             interrupt_request;

  int n_cmp = 0;
  int n_err = 0;

  timer_bank #(.WIDTH(WIDTH), .NCH(NCH), .SEL_BIT(SEL_BIT)) dut (
    .clk(clk),
    .reset(reset),
    .io_rd(io_rd),
    .io_wr(io_wr),
    .io_addr(io_addr),
    .io_dout(io_dout),
    .io_din(io_din),
    .irq_vec(irq_vec),
    .interrupt_request(interrupt_request)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [15:0] addr(input logic [3:0] ch, input logic [3:0] r);
    return 16'h4000 | {8'h00, ch, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [3:0] r, input logic [63:0] d);
    io_addr = addr(ch, r);
    io_dout = d;
    io_wr   = 1'b1;
    step();
    io_wr   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] ch, input logic [3:0] r,
                        input logic [63:0] exp);
    io_addr = addr(ch, r);
    io_rd   = 1'b1;
    #1;
    check(tag, io_din, exp);
    io_rd   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0;
    step(); step();
    reset = 1'b0;
    chk_rd("rst_count0", 0, 0, 0);
    chk_rd("rst_ctrl0", 0, 2, 0);
    chk_rd("rst_reload1", 1, 1, 0);
    chk_rd("rst_irqsum", 0, 4, 0);
    check("rst_irq_vec", 64'(irq_vec), 0);
    check("rst_intreq", 64'(interrupt_request), 0);

    // One-shot on ch0
    wr(0, 0, 3);
    step();
    chk_rd("os_frozen", 0, 0, 3);
    wr(0, 2, 5);
    step(); step(); step();
    chk_rd("os_status_pre", 0, 3, 0);
    chk_rd("os_count_zero", 0, 0, 0);
    step();
    chk_rd("os_status_set", 0, 3, 1);
    check("os_irq_latency", 64'(irq_vec), 0);
    chk_rd("os_en_cleared", 0, 2, 4);
    step();
    check("os_irq_vec", 64'(irq_vec), 1);
    check("os_intreq", 64'(interrupt_request), 1);
    chk_rd("os_count_hold", 0, 0, 0);
    wr(0, 3, 1);
    chk_rd("os_w1c", 0, 3, 0);
    step();
    check("os_irq_clr", 64'(irq_vec), 0);

    // Periodic on ch1, RELOAD=4
    wr(1, 1, 4);
    wr(1, 0, 0);
    wr(1, 2, 7);
    step();
    chk_rd("per_first_exp", 1, 3, 1);
    chk_rd("per_reload", 1, 0, 4);
    wr(1, 3, 1);
    chk_rd("per_w1c", 1, 3, 0);
    check("per_intreq_hi", 64'(interrupt_request), 1);
    step();
    check("per_intreq_clr", 64'(interrupt_request), 0);
    chk_rd("per_count2", 1, 0, 2);
    step(); step();
    chk_rd("per_status_pre", 1, 3, 0);
    chk_rd("per_count0", 1, 0, 0);
    step();
    chk_rd("per_second_exp", 1, 3, 1);
    chk_rd("per_reload2", 1, 0, 4);
    step();
    check("per_intreq_re", 64'(interrupt_request), 1);
    check("per_irq_vec", 64'(irq_vec), 2);

    // Simultaneous events on ch1
    wr(1, 3, 1);
    chk_rd("sim_pre_clr", 1, 3, 0);
    step(); step();
    chk_rd("sim_count0", 1, 0, 0);
    wr(1, 3, 1);
    chk_rd("sim_set_wins", 1, 3, 1);
    wr(1, 0, 9);
    chk_rd("sim_count_wr", 1, 0, 9);
    wr(1, 2, 0);
    chk_rd("sim_dis_count", 1, 0, 8);
    chk_rd("sim_dis_ctrl", 1, 2, 0);
    step();
    chk_rd("sim_frozen", 1, 0, 8);
    wr(1, 3, 1);
    chk_rd("sim_clr", 1, 3, 0);

    // CTRL write beats one-shot auto-clear on ch3
    wr(3, 2, 1);
    wr(3, 2, 1);
    chk_rd("ctl_wins_en", 3, 2, 1);
    chk_rd("ctl_wins_pend", 3, 3, 1);
    step();
    chk_rd("ctl_autoclr", 3, 2, 0);
    wr(3, 3, 1);
    chk_rd("ctl_clr", 3, 3, 0);

    // Mask and summary on ch2
    wr(2, 0, 1);
    wr(2, 2, 1);
    step();
    chk_rd("msk_status_pre", 2, 3, 0);
    step();
    chk_rd("msk_status", 2, 3, 1);
    chk_rd("msk_irqsum0", 5, 4, 0);
    step();
    check("msk_intreq0", 64'(interrupt_request), 0);
    wr(2, 2, 4);
    chk_rd("msk_irqsum", 0, 4, 4);
    chk_rd("msk_irqsum_ch7", 7, 4, 4);
    check("msk_intreq_lat", 64'(interrupt_request), 0);
    step();
    check("msk_intreq1", 64'(interrupt_request), 1);
    check("msk_irq_vec", 64'(irq_vec), 4);

    // Undefined registers and channels
    chk_rd("undef_reg6", 0, 6, 0);
    wr(5, 0, 64'h1234);
    chk_rd("undef_ch5", 5, 0, 0);
    chk_rd("undef_ch15", 15, 1, 0);
`ifndef TIMER_PRESCALER_EN
    wr(0, 5, 7);
    chk_rd("reg5_off", 0, 5, 0);
`endif

    // Address decode with select bit low, then reset mid-count
    wr(0, 0, 100);
    chk_rd("dec_count", 0, 0, 100);
    wr(0, 2, 1);
    chk_rd("dec_count_en", 0, 0, 100);
    step();
    chk_rd("dec_count_run", 0, 0, 99);
    for (int r = 0; r < 16; r++) begin
      io_addr = 16'(r);
      #1;
      check($sformatf("dec_nosel_r%0d", r), io_din, 0);
    end
    io_addr = 16'h0011;
    io_dout = 64'd77;
    io_wr   = 1'b1;
    step();
    io_wr   = 1'b0;
    chk_rd("dec_nosel_wr", 1, 1, 4);
    chk_rd("dec_count_98", 0, 0, 98);

    reset   = 1'b1;
    io_addr = addr(0, 0);
    io_dout = 64'd55;
    io_wr   = 1'b1;
    step();
    io_wr   = 1'b0;
    reset   = 1'b0;
    chk_rd("mid_rst_count", 0, 0, 0);
    chk_rd("mid_rst_ctrl", 0, 2, 0);
    chk_rd("mid_rst_reload1", 1, 1, 0);
    chk_rd("mid_rst_status2", 2, 3, 0);
    chk_rd("mid_rst_ctrl2", 2, 2, 0);
    check("mid_rst_irq_vec", 64'(irq_vec), 0);
    check("mid_rst_intreq", 64'(interrupt_request), 0);
    step();
    chk_rd("mid_rst_hold", 0, 0, 0);

`ifdef TIMER_PRESCALER_EN
    wr(0, 0, 1);
    wr(0, 5, 2);
    chk_rd("psc_read", 0, 5, 2);
    wr(0, 2, 1);
    step(); step(); step(); step();
    chk_rd("psc_pre", 0, 3, 0);
    step();
    chk_rd("psc_expiry", 0, 3, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
